reg_wport_arbiter: RTL and testbench

Shares the register file's single write port between two writers. The pipeline write-back stage has priority and is never back-pressured. A multi-cycle unit (divider, load miss) has its results buffered in a small FIFO. Drains the FIFO in idle write-port cycles, forces a pipeline stall when a buffered result starves, and reports read-after-write hazards against still-pending entries so decode can stall.

---
 rtl/reg_wport_arbiter_pkg.sv | 15 +
 rtl/reg_wport_arbiter_if.sv | 39 +++
 rtl/reg_wport_arbiter_pend.sv | 92 +++++++++
 rtl/reg_wport_arbiter.sv | 95 +++++++++
 tb/tb_reg_wport_arbiter.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_wport_arbiter_pkg.sv
// Shared constants for the register-file write-port arbiter.
//   WriteEnable / ReadEnable : active level of the write and read enables
//   zeroWord                 : all-zero data word
//   ARB_IDLE / ARB_DRAIN / ARB_FORCE : arbiter state encodings
package reg_wport_arbiter_pkg;

    localparam logic        WriteEnable = 1'b1;
    localparam logic        ReadEnable  = 1'b1;
    localparam logic [31:0] zeroWord    = 32'h0000_0000;

    localparam logic [1:0] ARB_IDLE  = 2'd0;  // no valid pending entry
    localparam logic [1:0] ARB_DRAIN = 2'd1;  // at least one valid pending entry
    localparam logic [1:0] ARB_FORCE = 2'd2;  // one-cycle forced drain, pipeline stalled

endpackage

// File: rtl/reg_wport_arbiter_if.sv
// Bundle of the write-port arbiter's bus signals.
//   p_*        : pipeline write-back (enable, address, data)
//   m_*        : multi-cycle unit result handshake (valid/ready, address, data)
//   stall_req  : arbiter asks the pipeline to freeze for one cycle
//   re*/raddr* : decode read ports, pend_hit* : hazard against pending entries
//   rf_*       : register-file write port
// master = pipeline/decode/multi-cycle side, slave = the arbiter.
interface reg_wport_arbiter_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic          p_we;
    logic [AW-1:0] p_waddr;
    logic [DW-1:0] p_wdata;
    logic          m_valid;
    logic [AW-1:0] m_waddr;
    logic [DW-1:0] m_wdata;
    logic          m_ready;
    logic          stall_req;
    logic          re1;
    logic          re2;
    logic [AW-1:0] raddr1;
    logic [AW-1:0] raddr2;
    logic          pend_hit1;
    logic          pend_hit2;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;

    modport master (
        output p_we, p_waddr, p_wdata, m_valid, m_waddr, m_wdata, re1, re2, raddr1, raddr2,
        input  m_ready, stall_req, pend_hit1, pend_hit2, rf_we, rf_waddr, rf_wdata
    );

    modport slave (
        input  p_we, p_waddr, p_wdata, m_valid, m_waddr, m_wdata, re1, re2, raddr1, raddr2,
        output m_ready, stall_req, pend_hit1, pend_hit2, rf_we, rf_waddr, rf_wdata
    );
endinterface

// File: rtl/reg_wport_arbiter_pend.sv
// pend_fifo: storage for buffered multi-cycle results.
//   store/store_addr/store_data : append an entry (marked valid)
//   pop                         : retire the head slot
//   kill_en/kill_addr           : clear the valid bit of every entry with that address
//   raddr1/raddr2 -> match1/2   : some valid stored entry carries that address
//   head_*                      : occupancy, validity and contents of the oldest slot
//   full                        : all slots occupied (killed-but-unpopped included)
//   any_valid_next              : a valid entry will remain after this cycle's update
module pend_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          store,
    input  logic [AW-1:0] store_addr,
    input  logic [DW-1:0] store_data,
    input  logic          pop,
    input  logic          kill_en,
    input  logic [AW-1:0] kill_addr,
    input  logic [AW-1:0] raddr1,
    input  logic [AW-1:0] raddr2,
    output logic          match1,
    output logic          match2,
    output logic          head_present,
    output logic          head_valid,
    output logic [AW-1:0] head_addr,
    output logic [DW-1:0] head_data,
    output logic          full,
    output logic          any_valid_next
);
    localparam int PW = $clog2(DEPTH);

    logic [AW-1:0]    addr_q [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_next;
    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic [PW:0]      count;

    assign head_present   = (count != '0);
    assign head_valid     = valid_q[rd_ptr];
    assign head_addr      = addr_q[rd_ptr];
    assign head_data      = data_q[rd_ptr];
    assign full           = (count == (PW+1)'(DEPTH));
    assign any_valid_next = |valid_next;

    // Kill and pop clear first, then a push sets its slot, so a same-cycle push with
    // the killed address survives, and a push into the slot being popped wins.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no latch is inferred.
        valid_next = valid_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (kill_en && valid_q[i] && (addr_q[i] == kill_addr)) valid_next[i] = 1'b0;
        end
        if (pop)   valid_next[rd_ptr] = 1'b0;
        if (store) valid_next[wr_ptr] = 1'b1;
    end

    always_comb begin
        match1 = 1'b0;
        match2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (addr_q[i] == raddr1)) match1 = 1'b1;
            if (valid_q[i] && (addr_q[i] == raddr2)) match2 = 1'b1;
        end
    end

    // NOTE: state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
        end else begin
            valid_q <= valid_next;
            if (pop)   rd_ptr <= rd_ptr + PW'(1);
            if (store) wr_ptr <= wr_ptr + PW'(1);
            count <= count + (PW+1)'(store) - (PW+1)'(pop);
        end
    end

    // NOTE: payload storage has no reset; the valid bits alone decide whether a slot means anything.
    always_ff @(posedge clk) begin
        if (store) begin
            addr_q[wr_ptr] <= store_addr;
            data_q[wr_ptr] <= store_data;
        end
    end

endmodule

// File: rtl/reg_wport_arbiter.sv
// reg_wport_arbiter: shares the register file's single write port between the
// pipeline write-back (priority, never back-pressured) and a buffered multi-cycle unit.
//   clk, rst : clock and asynchronous active-low reset
//   bus      : slave side of reg_wport_arbiter_if (pipeline, multi-cycle, decode, rf port)
module reg_wport_arbiter
    import reg_wport_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8,
    parameter int AW           = 5,
    parameter int DW           = 32
) (
    input logic                clk,
    input logic                rst,
    reg_wport_arbiter_if.slave bus
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [1:0]    state, state_next;
    logic [CW-1:0] wait_cnt, wait_cnt_next;
    logic          force_st, p_we_on, p_grant, m_grant, pop, starve, store, kill_en;
    logic          head_present, head_valid, full, any_valid_next, match1, match2;
    logic [AW-1:0] head_addr;
    logic [DW-1:0] head_data;

    assign force_st = (state == ARB_FORCE);
    assign p_we_on  = (bus.p_we == WriteEnable);

    // In FORCE the pipeline enable is ignored and the head owns the port.
    assign p_grant = p_we_on && !force_st;
    assign m_grant = head_valid && (force_st || !p_we_on);
    // Killed heads leave without using the port, in any state.
    assign pop     = head_present && (force_st || !head_valid || !p_we_on);
    assign starve  = head_valid && !m_grant;

    // Address-0 results complete the handshake but are never stored.
    assign store   = bus.m_valid && bus.m_ready && (bus.m_waddr != '0);
    assign kill_en = p_grant && (bus.p_waddr != '0);

    // A full FIFO can still accept in FORCE because the head pop is certain.
    assign bus.m_ready   = !full || force_st;
    assign bus.stall_req = force_st;
    assign bus.rf_we     = p_grant || m_grant;
    assign bus.rf_waddr  = p_grant ? bus.p_waddr : (m_grant ? head_addr : '0);
    assign bus.rf_wdata  = p_grant ? bus.p_wdata : (m_grant ? head_data : DW'(zeroWord));
    assign bus.pend_hit1 = (bus.re1 == ReadEnable) && (bus.raddr1 != '0) && match1;
    assign bus.pend_hit2 = (bus.re2 == ReadEnable) && (bus.raddr2 != '0) && match2;

    pend_fifo #(
        .DEPTH (FIFO_DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_pend_fifo (
        .clk            (clk),
        .rst            (rst),
        .store          (store),
        .store_addr     (bus.m_waddr),
        .store_data     (bus.m_wdata),
        .pop            (pop),
        .kill_en        (kill_en),
        .kill_addr      (bus.p_waddr),
        .raddr1         (bus.raddr1),
        .raddr2         (bus.raddr2),
        .match1         (match1),
        .match2         (match2),
        .head_present   (head_present),
        .head_valid     (head_valid),
        .head_addr      (head_addr),
        .head_data      (head_data),
        .full           (full),
        .any_valid_next (any_valid_next)
    );

    // A starved head is always present and unpopped, so every other case clears
    // the counter. Reaching STARVE_LIMIT-1 schedules the forced drain.
    always_comb begin
        wait_cnt_next = '0;
        state_next    = any_valid_next ? ARB_DRAIN : ARB_IDLE;
        if (starve) begin
            wait_cnt_next = wait_cnt + CW'(1);
            if (wait_cnt == CW'(STARVE_LIMIT - 2)) state_next = ARB_FORCE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ARB_IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

endmodule

// File: tb/tb_reg_wport_arbiter.sv
// Self-checking bench for reg_wport_arbiter: directed vector table, hand-written
// multi-cycle sequences, then random traffic against a queue-based reference model.
module tb_reg_wport_arbiter;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int SL    = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    reg_wport_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    reg_wport_arbiter #(
        .FIFO_DEPTH   (DEPTH),
        .STARVE_LIMIT (SL),
        .AW           (AW),
        .DW           (DW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // One cycle of stimulus and the outputs required while it is applied.
    typedef struct {
        int pw; int pa; logic [31:0] pd;
        int mv; int ma; logic [31:0] md;
        int r1; int a1; int r2; int a2;
        int we; int ea; logic [31:0] ed;
        int mr; int st; int h1; int h2;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    typedef struct {
        int          addr;
        logic [31:0] data;
        int          valid;
    } ent_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int pw, input int pa, input logic [31:0] pd,
                         input int mv, input int ma, input logic [31:0] md,
                         input int r1, input int a1, input int r2, input int a2);
        bus.p_we    = (pw != 0);
        bus.p_waddr = AW'(pa);
        bus.p_wdata = pd;
        bus.m_valid = (mv != 0);
        bus.m_waddr = AW'(ma);
        bus.m_wdata = md;
        bus.re1     = (r1 != 0);
        bus.raddr1  = AW'(a1);
        bus.re2     = (r2 != 0);
        bus.raddr2  = AW'(a2);
    endtask

    task automatic idle();
        drive(0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 0);
    endtask

    // Address/data of the rf port only matter while rf_we is high.
    task automatic expect_out(input string tag, input int we, input int a, input logic [31:0] d,
                              input int mr, input int st, input int h1, input int h2);
        logic          ewe;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        ewe = (we != 0);
        ea  = ewe ? AW'(a) : '0;
        ed  = ewe ? d : '0;
        check({tag, " rf{we,addr,data}"},
              64'({bus.rf_we, bus.rf_we ? bus.rf_waddr : 5'd0, bus.rf_we ? bus.rf_wdata : 32'd0}),
              64'({ewe, ea, ed}));
        check({tag, " {m_ready,stall_req,pend_hit1,pend_hit2}"},
              64'({bus.m_ready, bus.stall_req, bus.pend_hit1, bus.pend_hit2}),
              64'({mr != 0, st != 0, h1 != 0, h2 != 0}));
    endtask

    // The pipeline must never write while the arbiter is forcing a drain.
    always @(negedge clk) begin
        if (rst && bus.stall_req && bus.p_we) begin
            errors++;
            $display("FAIL p_we_in_force: p_we=1 while stall_req=1 at %0t", $time);
        end
    end

    // Reference model: the FIFO is a queue of {addr,data,valid}; each cycle applies the
    // arbitration rules in priority order, then pop, kill, push and the starvation count.
    task automatic run_random(input int n);
        ent_t        q [$];
        ent_t        e;
        int          frc, waited, nf, hv, gh, popped;
        int          pw, pa, mv, ma, r1, a1, r2, a2, pct;
        int          e_we, e_a, e_mr, h1, h2;
        logic [31:0] pd, md, e_d;
        frc    = 0;
        waited = 0;
        for (int cyc = 0; cyc < n; cyc++) begin
            pct = (cyc < n / 3) ? 50 : ((cyc < 2 * n / 3) ? 90 : 15);
            pw  = (frc == 0 && $urandom_range(0, 99) < pct) ? 1 : 0;
            pa  = $urandom_range(0, 15);
            pd  = $urandom;
            mv  = $urandom_range(0, 1);
            ma  = $urandom_range(0, 15);
            md  = $urandom;
            r1  = $urandom_range(0, 1);
            a1  = $urandom_range(0, 15);
            r2  = $urandom_range(0, 1);
            a2  = $urandom_range(0, 15);
            drive(pw, pa, pd, mv, ma, md, r1, a1, r2, a2);
            #1;

            hv = 0;
            if (q.size() != 0) hv = q[0].valid;
            e_mr = (frc != 0 || q.size() < DEPTH) ? 1 : 0;
            gh = 0; e_we = 0; e_a = 0; e_d = 32'h0;
            if (frc != 0) begin
                if (hv != 0) begin gh = 1; e_we = 1; e_a = q[0].addr; e_d = q[0].data; end
            end else if (pw != 0) begin
                e_we = 1; e_a = pa; e_d = pd;
            end else if (hv != 0) begin
                gh = 1; e_we = 1; e_a = q[0].addr; e_d = q[0].data;
            end
            h1 = 0;
            h2 = 0;
            foreach (q[i]) begin
                if (q[i].valid != 0 && r1 != 0 && a1 != 0 && q[i].addr == a1) h1 = 1;
                if (q[i].valid != 0 && r2 != 0 && a2 != 0 && q[i].addr == a2) h2 = 1;
            end
            expect_out($sformatf("rnd%0d", cyc), e_we, e_a, e_d, e_mr, frc, h1, h2);

            popped = (q.size() != 0 && (frc != 0 || gh != 0 || hv == 0)) ? 1 : 0;
            nf = 0;
            if (popped != 0 || q.size() == 0) begin
                waited = 0;
            end else begin
                waited++;
                nf = (waited == SL - 1) ? 1 : 0;
            end
            if (popped != 0) void'(q.pop_front());
            if (pw != 0 && pa != 0) begin
                foreach (q[i]) begin
                    if (q[i].addr == pa) begin e = q[i]; e.valid = 0; q[i] = e; end
                end
            end
            if (mv != 0 && e_mr != 0 && ma != 0) begin
                e.addr = ma; e.data = md; e.valid = 1;
                q.push_back(e);
            end
            frc = nf;
            tick();
        end
        idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //           pw pa  pd            mv ma  md            r1 a1  r2 a2   we ea  ed            mr st h1 h2
        vecs[0]  = '{0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  0, 0,   0, 0,  32'h0,        1, 0, 0, 0};
        vecs[1]  = '{0, 0,  32'h0,        1, 5,  32'hAAAA0001, 1, 5,  0, 0,   0, 0,  32'h0,        1, 0, 0, 0};
        vecs[2]  = '{0, 0,  32'h0,        0, 0,  32'h0,        1, 5,  0, 0,   1, 5,  32'hAAAA0001, 1, 0, 1, 0};
        vecs[3]  = '{0, 0,  32'h0,        0, 0,  32'h0,        1, 5,  0, 0,   0, 0,  32'h0,        1, 0, 0, 0};
        vecs[4]  = '{1, 3,  32'h33,       1, 12, 32'hC,        0, 0,  0, 0,   1, 3,  32'h33,       1, 0, 0, 0};
        vecs[5]  = '{1, 4,  32'h44,       0, 0,  32'h0,        1, 12, 1, 12,  1, 4,  32'h44,       1, 0, 1, 1};
        vecs[6]  = '{1, 4,  32'h45,       0, 0,  32'h0,        0, 12, 1, 0,   1, 4,  32'h45,       1, 0, 0, 0};
        vecs[7]  = '{1, 6,  32'h66,       0, 0,  32'h0,        1, 12, 1, 13,  1, 6,  32'h66,       1, 0, 1, 0};
        vecs[8]  = '{0, 0,  32'h0,        0, 0,  32'h0,        1, 12, 0, 0,   1, 12, 32'hC,        1, 0, 1, 0};
        vecs[9]  = '{0, 0,  32'h0,        1, 9,  32'h1,        1, 9,  0, 0,   0, 0,  32'h0,        1, 0, 0, 0};
        vecs[10] = '{1, 9,  32'h2,        0, 0,  32'h0,        1, 9,  0, 0,   1, 9,  32'h2,        1, 0, 1, 0};
        vecs[11] = '{0, 0,  32'h0,        0, 0,  32'h0,        1, 9,  0, 0,   0, 0,  32'h0,        1, 0, 0, 0};
        vecs[12] = '{0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  1, 9,   0, 0,  32'h0,        1, 0, 0, 0};
        vecs[13] = '{0, 0,  32'h0,        1, 0,  32'hDEAD,     0, 0,  0, 0,   0, 0,  32'h0,        1, 0, 0, 0};
        vecs[14] = '{0, 0,  32'h0,        0, 0,  32'h0,        1, 0,  0, 0,   0, 0,  32'h0,        1, 0, 0, 0};
        vecs[15] = '{1, 0,  32'h77,       0, 0,  32'h0,        0, 0,  0, 0,   1, 0,  32'h77,       1, 0, 0, 0};
        vecs[16] = '{1, 10, 32'hA1,       1, 10, 32'hB2,       1, 10, 0, 0,   1, 10, 32'hA1,       1, 0, 0, 0};
        vecs[17] = '{0, 0,  32'h0,        0, 0,  32'h0,        1, 10, 0, 0,   1, 10, 32'hB2,       1, 0, 1, 0};
        vecs[18] = '{0, 0,  32'h0,        0, 0,  32'h0,        1, 10, 0, 0,   0, 0,  32'h0,        1, 0, 0, 0};

        // Reset state
        drive(0, 0, 32'h0, 0, 0, 32'h0, 1, 5, 1, 7);
        #2;
        expect_out("reset", 0, 0, 32'h0, 1, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // Directed vectors: idle drain, hazards, kill ordering, address 0, same-cycle push
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].pw, vecs[i].pa, vecs[i].pd, vecs[i].mv, vecs[i].ma, vecs[i].md,
                  vecs[i].r1, vecs[i].a1, vecs[i].r2, vecs[i].a2);
            #1;
            expect_out($sformatf("vec%0d", i), vecs[i].we, vecs[i].ea, vecs[i].ed,
                       vecs[i].mr, vecs[i].st, vecs[i].h1, vecs[i].h2);
            tick();
        end

        // Starvation: r7 waits under continuous pipeline writes, forced in the 8th cycle
        drive(1, 1, 32'h100, 1, 7, 32'h7777, 1, 7, 0, 0);
        #1;
        expect_out("starve push", 1, 1, 32'h100, 1, 0, 0, 0);
        tick();
        for (int k = 1; k <= 7; k++) begin
            drive(1, 1, 32'h100 + k, 0, 0, 32'h0, 1, 7, 0, 0);
            #1;
            expect_out($sformatf("starve wait%0d", k), 1, 1, 32'h100 + k, 1, 0, 1, 0);
            tick();
        end
        drive(0, 0, 32'h0, 0, 0, 32'h0, 1, 7, 0, 0);
        #1;
        expect_out("starve force", 1, 7, 32'h7777, 1, 1, 1, 0);
        tick();
        drive(1, 1, 32'h108, 0, 0, 32'h0, 1, 7, 0, 0);
        #1;
        expect_out("starve after", 1, 1, 32'h108, 1, 0, 0, 0);
        tick();

        // Full: four pushes under pipeline writes, fifth refused, r0 push accepted and dropped
        for (int k = 0; k < 4; k++) begin
            drive(1, 1, 32'h10 + k, 1, 16 + k, 32'hF0 + k, 0, 0, 0, 0);
            #1;
            expect_out($sformatf("full push%0d", k), 1, 1, 32'h10 + k, 1, 0, 0, 0);
            tick();
        end
        drive(1, 1, 32'h14, 1, 20, 32'hF4, 0, 0, 0, 0);
        #1;
        expect_out("full refused", 1, 1, 32'h14, 0, 0, 0, 0);
        tick();
        drive(0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 0);
        #1;
        expect_out("full drain0", 1, 16, 32'hF0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 32'h0, 1, 0, 32'hDEAD, 0, 0, 0, 0);
        #1;
        expect_out("full drain1 r0push", 1, 17, 32'hF1, 1, 0, 0, 0);
        tick();
        for (int k = 2; k < 4; k++) begin
            idle();
            #1;
            expect_out($sformatf("full drain%0d", k), 1, 16 + k, 32'hF0 + k, 1, 0, 0, 0);
            tick();
        end
        idle();
        #1;
        expect_out("full empty", 0, 0, 32'h0, 1, 0, 0, 0);
        tick();

        // Reset mid-drain: three entries queued, one cycle of reset wipes them
        for (int k = 0; k < 3; k++) begin
            drive(1, 2, 32'h200 + k, 1, 21 + k, 32'h2100 + k, 0, 0, 0, 0);
            #1;
            expect_out($sformatf("rstseq push%0d", k), 1, 2, 32'h200 + k, 1, 0, 0, 0);
            tick();
        end
        rst = 1'b0;
        drive(0, 0, 32'h0, 0, 0, 32'h0, 1, 21, 1, 22);
        #1;
        expect_out("rstseq async", 0, 0, 32'h0, 1, 0, 0, 0);
        tick();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 32'h0, 0, 0, 32'h0, 1, 21, 1, 23);
            #1;
            expect_out($sformatf("rstseq after%0d", k), 0, 0, 32'h0, 1, 0, 0, 0);
            tick();
        end

        // Random traffic against the reference model, starting from the empty state
        run_random(3000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
